butterfly_control: RTL and testbench

- Sequencer FSM directly upstream of the butterfly datapath. It drives every datapath control strobe.
- The user enters Re(w), Im(w), Re(b), Im(b), Re(a) and Im(a) on the switches, one value per push of a single board key.
- The block runs the two multiply passes automatically, then steps the four results (a±wb, real and imaginary) onto the LEDs.
- It contains a key synchroniser and debouncer, so one physical press advances exactly one step.

---
 rtl/butterfly_control.sv | 169 ++++++++++++++++
 tb/tb_butterfly_control.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_control.sv
// ---------------------------------------------------------------------------
// butterfly_control
//
// Sequencer for the butterfly datapath. One push of the board key enters one
// operand (Re(w), Im(w), Re(b), Im(b), then Re(a) and Im(a) later in the
// sequence). The two multiply passes run automatically. The four results
// a+wb / a-wb (real and imaginary) are then stepped onto the LEDs.
//
// The raw key is synchronised and debounced here, so one physical press
// advances the sequence by exactly one step.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-low reset
//   key_n           raw push-button, low = pressed, asynchronous to clk
//   load_coeff      datapath coefficient load strobe
//   load_b          datapath b pipeline load/shift strobe
//   load_mult       datapath multiplier input register load
//   multiply        datapath multiplier output register enable
//   load_output_reg datapath LED/feedback register enable
//   subtract        datapath add/sub select (1 = subtract)
//   mult_out_select datapath multiplier-output mux select
//   fbr_input       feedback register loads data_in
//   step            current state index, for the HEX display
//   busy            high while in an automatic (one-cycle) state
// ---------------------------------------------------------------------------
module butterfly_control #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       load_coeff,
    output logic       load_b,
    output logic       load_mult,
    output logic       multiply,
    output logic       load_output_reg,
    output logic       subtract,
    output logic       mult_out_select,
    output logic       fbr_input,
    output logic [3:0] step,
    output logic       busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Control word bit positions, packed as
    // {load_coeff, load_b, load_mult, multiply,
    //  load_output_reg, subtract, mult_out_select, fbr_input}
    localparam logic [7:0] W_COEFF = 8'b1000_0000;
    localparam logic [7:0] W_LDB   = 8'b0100_0000;
    localparam logic [7:0] W_LDM   = 8'b0010_0000;
    localparam logic [7:0] W_MUL   = 8'b0001_0000;
    localparam logic [7:0] W_OUT   = 8'b0000_1000;
    localparam logic [7:0] W_SUB   = 8'b0000_0100;
    localparam logic [7:0] W_MSEL  = 8'b0000_0010;
    localparam logic [7:0] W_FBR   = 8'b0000_0001;

    typedef enum logic [3:0] {
        W_REW  = 4'd0,
        W_IMW  = 4'd1,
        W_REB  = 4'd2,
        W_IMB  = 4'd3,
        M_LOAD = 4'd4,
        M_RE   = 4'd5,
        M_IM   = 4'd6,
        W_REA  = 4'd7,
        O_REP  = 4'd8,
        W_REM  = 4'd9,
        W_IMA  = 4'd10,
        O_IMP  = 4'd11,
        W_IMM  = 4'd12
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   released_q, released_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_pulse;
    state_t                 state_q, state_d;
    logic [7:0]             word_q, word_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Debouncer: count cycles in which the synchronised key disagrees with
    // the debounced level. Once the count has reached DEBOUNCE_CYCLES, the
    // level follows the key. Any agreeing cycle restarts the count, so a
    // bounce never accumulates across glitches.
    always_comb begin
        released_d = released_q;
        cnt_d      = '0;
        if (synced != released_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                released_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The press is taken from the combinational next level. The FSM can
    // then advance on the same edge at which the debounced level flips.
    assign press_pulse = released_q & ~released_d;

    // Sequencer next state and control word. A state's word is loaded as
    // the state is exited, so the datapath sees it for exactly one cycle.
    // Wait states ignore everything but a press. Automatic states ignore
    // presses entirely, so a press is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        word_d  = '0;
        case (state_q)
            W_REW:  if (press_pulse) begin state_d = W_IMW; word_d = W_COEFF; end
            W_IMW:  if (press_pulse) begin state_d = W_REB; word_d = W_COEFF; end
            W_REB:  if (press_pulse) begin state_d = W_IMB; word_d = W_LDB;   end
            W_IMB:  if (press_pulse) begin state_d = M_LOAD; word_d = W_LDB;  end
            M_LOAD: begin state_d = M_RE;  word_d = W_LDM | W_LDB;         end
            M_RE:   begin state_d = M_IM;  word_d = W_MUL | W_SUB | W_LDM; end
            M_IM:   begin state_d = W_REA; word_d = W_MUL;                 end
            W_REA:  if (press_pulse) begin state_d = O_REP; word_d = W_OUT | W_FBR; end
            O_REP:  begin state_d = W_REM; word_d = W_OUT;                 end
            W_REM:  if (press_pulse) begin state_d = W_IMA; word_d = W_OUT | W_SUB; end
            W_IMA:  if (press_pulse) begin
                        state_d = O_IMP;
                        word_d  = W_OUT | W_FBR | W_MSEL;
                    end
            O_IMP:  begin state_d = W_IMM; word_d = W_OUT | W_MSEL;        end
            W_IMM:  if (press_pulse) begin
                        state_d = W_REW;
                        word_d  = W_OUT | W_SUB | W_MSEL;
                    end
            default: state_d = W_REW;
        endcase
    end

    // Registers. The synchroniser and the debounced level reset to the
    // released level. A key held through reset therefore produces a single
    // fresh press once the debounce latency has elapsed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '1;
            released_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= W_REW;
            word_q     <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], key_n};
            released_q <= released_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            word_q     <= word_d;
        end
    end

    assign load_coeff      = word_q[7];
    assign load_b          = word_q[6];
    assign load_mult       = word_q[5];
    assign multiply        = word_q[4];
    assign load_output_reg = word_q[3];
    assign subtract        = word_q[2];
    assign mult_out_select = word_q[1];
    assign fbr_input       = word_q[0];

    assign step = state_q;
    assign busy = (state_q == M_LOAD) || (state_q == M_RE) || (state_q == M_IM) ||
                  (state_q == O_REP)  || (state_q == O_IMP);

endmodule

// File: tb/tb_butterfly_control.sv
// ---------------------------------------------------------------------------
// tb_butterfly_control
//
// Self-checking bench for butterfly_control. The reference model tracks the
// history of key samples. The debounced level flips at edge t when the
// samples taken at edges t-(SYNC+DEB) .. t-SYNC all oppose the current level.
// The sequence itself is a table of state words, walked by index.
// ---------------------------------------------------------------------------
module tb_butterfly_control;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int LAT  = SYNC + DEB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       key_n = 1'b1;
    logic       load_coeff, load_b, load_mult, multiply;
    logic       load_output_reg, subtract, mult_out_select, fbr_input;
    logic [3:0] step;
    logic       busy;

    always #5 clk = ~clk;

    butterfly_control #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_n          (key_n),
        .load_coeff     (load_coeff),
        .load_b         (load_b),
        .load_mult      (load_mult),
        .multiply       (multiply),
        .load_output_reg(load_output_reg),
        .subtract       (subtract),
        .mult_out_select(mult_out_select),
        .fbr_input      (fbr_input),
        .step           (step),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    // Observed outputs packed as {step, busy, word}, where word is
    // {load_coeff, load_b, load_mult, multiply,
    //  load_output_reg, subtract, mult_out_select, fbr_input}.
    logic [12:0] obs;
    assign obs = {step, busy, load_coeff, load_b, load_mult, multiply,
                  load_output_reg, subtract, mult_out_select, fbr_input};

    // Word emitted when leaving each state 0..12.
    logic [7:0] wordTable [13] = '{8'h80, 8'h80, 8'h40, 8'h40, 8'h60, 8'h34, 8'h10,
                                  8'h09, 8'h08, 8'h0C, 8'h0B, 8'h0A, 8'h0E};

    bit          samp[$];
    int          mIdx;
    bit          mLevel;
    logic [12:0] expv;

    function automatic bit isAuto(input int s);
        return (s == 4) || (s == 5) || (s == 6) || (s == 8) || (s == 11);
    endfunction

    task automatic modelReset();
        mIdx   = 0;
        mLevel = 1'b1;
        samp.delete();
        expv   = '0;
    endtask

    task automatic modelStep(input bit k);
        int         t;
        bit         flip;
        bit         pressNow;
        bit         adv;
        logic [7:0] w;
        samp.push_back(k);
        t    = samp.size() - 1;
        flip = 1'b1;
        for (int j = t - LAT; j <= t - SYNC; j++) begin
            bit v;
            v = (j < 0) ? 1'b1 : samp[j];
            if (v == mLevel) flip = 1'b0;
        end
        pressNow = 1'b0;
        if (flip) begin
            mLevel   = ~mLevel;
            pressNow = (mLevel == 1'b0);
        end
        adv = isAuto(mIdx) || pressNow;
        w   = adv ? wordTable[mIdx] : 8'h00;
        if (adv) mIdx = (mIdx == 12) ? 0 : mIdx + 1;
        expv = {4'(mIdx), isAuto(mIdx), w};
    endtask

    // One clock: present the key, let the edge happen, update the model and
    // leave the caller 1 ns after the edge, ready to compare.
    task automatic cycle(input bit k);
        key_n = k;
        @(posedge clk);
        modelStep(k);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got %h required %h", obs, 13'h0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1);
            checks++;
            if (obs !== 13'h0 || obs !== expv) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h required %h", i, obs, 13'h0);
            end
        end
    endtask

    task automatic test_clean_press();
        int firstSeen = -1;
        int pulses    = 0;
        doReset();
        for (int i = 0; i < 80; i++) begin
            cycle(i < 40 ? 1'b0 : 1'b1);
            if (load_coeff === 1'b1) begin
                pulses++;
                if (firstSeen < 0) firstSeen = i;
            end
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL clean_press cycle %0d: got %h required %h", i, obs, expv);
            end
        end
        checks++;
        if (firstSeen != LAT) begin
            errors++;
            $display("[TB] FAIL clean_press_latency: got %0d required %0d", firstSeen, LAT);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL clean_press_count: got %0d required 1", pulses);
        end
    endtask

    task automatic test_four_presses();
        logic [7:0] seen[$];
        logic [7:0] want[7] = '{8'h80, 8'h80, 8'h40, 8'h40, 8'h60, 8'h34, 8'h10};
        int busyCycles = 0;
        doReset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 50; i++) begin
                cycle(i < 25 ? 1'b0 : 1'b1);
                if (obs[7:0] !== 8'h00) seen.push_back(obs[7:0]);
                if (busy === 1'b1) busyCycles++;
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL four_presses p%0d c%0d: got %h required %h", p, i, obs, expv);
                end
            end
        end
        checks++;
        if (seen.size() != 7) begin
            errors++;
            $display("[TB] FAIL four_presses_words: got %0d words required 7", seen.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    errors++;
                    $display("[TB] FAIL four_presses_word%0d: got %h required %h", i, seen[i], want[i]);
                end
            end
        end
        checks++;
        if (busyCycles != 3 || step !== 4'd7) begin
            errors++;
            $display("[TB] FAIL four_presses_end: got busy=%0d step=%0d required busy=3 step=7", busyCycles, step);
        end
    endtask

    task automatic test_bounce();
        int cyc = 0;
        int acceptAt = -1;
        doReset();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                cycle(i < 5 ? 1'b0 : 1'b1);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL bounce cycle %0d: got %h required %h", cyc, obs, expv);
                end
                cyc++;
            end
        end
        for (int i = 0; i < 70; i++) begin
            cycle(i < 40 ? 1'b0 : 1'b1);
            if (acceptAt < 0 && step === 4'd1) acceptAt = i;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL bounce cycle %0d: got %h required %h", cyc, obs, expv);
            end
            cyc++;
        end
        checks++;
        if (acceptAt != LAT) begin
            errors++;
            $display("[TB] FAIL bounce_latency: got %0d required %0d", acceptAt, LAT);
        end
    endtask

    task automatic test_full_sequence();
        logic [7:0] seen[$];
        logic [7:0] want[15] = '{8'h80, 8'h80, 8'h40, 8'h40, 8'h60, 8'h34, 8'h10, 8'h09,
                                 8'h08, 8'h0C, 8'h0B, 8'h0A, 8'h0E, 8'h80, 8'h80};
        doReset();
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 50; i++) begin
                cycle(i < 25 ? 1'b0 : 1'b1);
                if (obs[7:0] !== 8'h00) seen.push_back(obs[7:0]);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL full_seq p%0d c%0d: got %h required %h", p, i, obs, expv);
                end
            end
            if (p == 7) begin
                checks++;
                if (step !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL full_seq_wrap: got step %0d required 0", step);
                end
            end
        end
        checks++;
        if (seen.size() != 15) begin
            errors++;
            $display("[TB] FAIL full_seq_words: got %0d words required 15", seen.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (seen[i] !== want[i]) begin
                    errors++;
                    $display("[TB] FAIL full_seq_word%0d: got %h required %h", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int remaining = 0;
        bit level     = 1'b1;
        doReset();
        for (int i = 0; i < 1200; i++) begin
            if (remaining == 0) begin
                level     = ~level;
                remaining = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12)
                                                         : $urandom_range(15, 45);
            end
            remaining--;
            cycle(level);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h required %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_reset_midseq();
        int firstSeen = -1;
        doReset();
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 50; i++) begin
                cycle(i < 25 ? 1'b0 : 1'b1);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("[TB] FAIL midseq p%0d c%0d: got %h required %h", p, i, obs, expv);
                end
            end
        end
        checks++;
        if (step !== 4'd9) begin
            errors++;
            $display("[TB] FAIL midseq_state: got step %0d required 9", step);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("[TB] FAIL midseq_async_reset: got %h required %h", obs, 13'h0);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("[TB] FAIL midseq_reset_hold: got %h required %h", obs, 13'h0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 70; i++) begin
            cycle(i < 40 ? 1'b0 : 1'b1);
            if (firstSeen < 0 && load_coeff === 1'b1) firstSeen = i;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL midseq_after cycle %0d: got %h required %h", i, obs, expv);
            end
        end
        checks++;
        if (firstSeen != LAT) begin
            errors++;
            $display("[TB] FAIL midseq_latency: got %0d required %0d", firstSeen, LAT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        test_reset();
        test_clean_press();
        test_four_presses();
        test_bounce();
        test_full_sequence();
        test_random();
        test_reset_midseq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
